multi_digit_display: RTL and testbench
======================================

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 SHALL have parameter NDIG, default 8: number of multiplexed digits, range 2..16.
REQ-002 SHALL have parameter FCLK_KHZ, default 50000: clock frequency in kHz.
REQ-003 SHALL have parameter FSCAN_KHZ, default 1: digit-switch rate in kHz; DIV = FCLK_KHZ/FSCAN_KHZ, DIV >= 1.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port dat, input, 4*NDIG: hex nibbles; digit i = dat[4i+3:4i], digit 0 least significant.
REQ-007 SHALL have port dp_mask, input, NDIG: bit i=1 lights the point on digit i.
REQ-008 SHALL have port load, input, 1: on a high cycle, capture dat/dp_mask into shadow registers.
REQ-009 SHALL have port blank_lz, input, 1: leading-zero blanking enable, sampled live.
REQ-010 SHALL have port bright, input, 3: brightness level 0..7.
REQ-011 SHALL have port AN, output, NDIG: active-low anodes.
REQ-012 SHALL have port seg, output, 7: active-low segments, order gfedcba.
REQ-013 SHALL have port seg_P, output, 1: active-low decimal point.
REQ-014 SHALL have port ce_scan, output, 1: one-cycle scan strobe.

Function
REQ-015 Prescaler SHALL count cb <= ce_scan ? 1 : cb+1, width clog2(DIV+1); ce_scan = (cb == DIV).
REQ-016 Digit index SHALL increment on ce_scan, 0..NDIG-1, wrapping NDIG-1 -> 0.
REQ-017 Shadow dat/dp SHALL load on the clk edge where load=1; display SHALL use shadow only; seg reflects new data the cycle after load.
REQ-018 load coincident with ce_scan SHALL apply both: next cycle shows the new digit index with new shadow data.
REQ-019 Active digit i SHALL drive AN[i]=0, all other AN bits 1, when not blanked and PWM-on.
REQ-020 seg SHALL decode the nibble as 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
REQ-021 seg_P SHALL be ~dp_shadow[i] for the active digit i.
REQ-022 With blank_lz=1, digit i (i>0) SHALL be blanked when shadow nibbles NDIG-1..i are all zero; digit 0 SHALL never be blanked.
REQ-023 Blanked digit: AN all 1, seg 7'h7F, seg_P 1.
REQ-024 A 3-bit PWM counter SHALL increment every clock, wrapping 7 -> 0; anodes SHALL be enabled only while pwm_cnt <= bright (bright=7 always on, bright=0 on 1/8 of cycles).
REQ-025 seg/seg_P SHALL not depend on PWM; only AN is gated.
REQ-026 All outputs SHALL be combinational from registered state plus blank_lz/bright; no other latency.

Reset
REQ-027 rst=1 SHALL clear cb, digit index, pwm_cnt, and the shadow dat and dp registers to 0.
REQ-028 The cycle after reset: AN = ~1 (only AN[0] low), seg = 1000000, seg_P = 1, ce_scan = 0.
REQ-029 Reset SHALL take priority over load and ce_scan; reset mid-scan SHALL restart at digit 0 with a full DIV period.

Configuration
REQ-030 Macro SEG_PWM_EN defined: brightness PWM per REQ-024 is compiled in.
REQ-031 SEG_PWM_EN undefined: no PWM counter; bright is ignored; anodes are on for the whole slot.

Verification (NDIG=4, FCLK_KHZ=4, FSCAN_KHZ=1, DIV=4, SEG_PWM_EN defined, bright=7)
REQ-032 rst 1 cycle, then run 20 cycles -> ce_scan high on cycles 4,8,12,16; AN sequence 1110,1101,1011,0111,1110.
REQ-033 dat=16'h12AF, load pulse, dp_mask=4'b0100 -> seg reads 0001110 / 0001000 / 0100100 / 1111001 for digits 0..3; seg_P=0 only on digit 2.
REQ-034 dat=16'h0050, blank_lz=1 -> digits 3 and 2 give AN=1111 and seg=7F; digits 1 and 0 show 5 and 0; with blank_lz=0 all four are shown.
REQ-035 bright=2, digit slot held -> AN active for 3 of every 8 cycles; seg constant; with SEG_PWM_EN undefined, always active.
REQ-036 load asserted on the same edge as ce_scan with new dat -> first cycle of the new digit shows the new nibble; rst asserted mid-slot -> next cycle digit 0, cb restarts, seg=1000000.

Source files
------------

// File: rtl/multi_digit_display.sv
// multi_digit_display: time-multiplexed hex display driver for NDIG digits.
// Shadow-registered data and decimal points, optional leading-zero blanking,
// active-low anodes and segments (gfedcba) plus a one-cycle scan strobe.
// Optional feature: define SEG_PWM_EN to compile in the 3-bit brightness
// PWM that gates the anodes. Without it, bright is ignored.
module multi_digit_display #(
   parameter int unsigned NDIG      = 8,
   parameter int unsigned FCLK_KHZ  = 50000,
   parameter int unsigned FSCAN_KHZ = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4*NDIG-1:0] dat,
   input  logic [NDIG-1:0]   dp_mask,
   input  logic              load,
   input  logic              blank_lz,
   input  logic [2:0]        bright,
   output logic [NDIG-1:0]   AN,
   output logic [6:0]        seg,
   output logic              seg_P,
   output logic              ce_scan
);

   localparam int unsigned DIV = FCLK_KHZ / FSCAN_KHZ;
   localparam int unsigned CBW = $clog2(DIV + 1);
   localparam int unsigned IW  = $clog2(NDIG);

   logic [CBW-1:0]    r_cb;
   logic [IW-1:0]     r_idx;
   logic [4*NDIG-1:0] r_dat;
   logic [NDIG-1:0]   r_dp;

   logic              w_ce;
   logic [3:0]        w_nib;
   logic [6:0]        w_seg_dec;
   logic [NDIG-1:0]   w_lz;
   logic              w_blank;
   logic              w_pwm_on;

   assign w_ce = (r_cb == CBW'(DIV));

   // Scan prescaler: reloads to 1 on the strobe so later periods are DIV long
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cb <= '0;
      end else if (w_ce) begin
         r_cb <= CBW'(1);
      end else begin
         r_cb <= r_cb + CBW'(1);
      end
   end

   // Active digit index, advances once per scan strobe and wraps at NDIG-1
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else if (w_ce) begin
         if (r_idx == IW'(NDIG - 1)) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   // Shadow copies of digit data and decimal points; display reads only these
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dat <= '0;
         r_dp  <= '0;
      end else if (load) begin
         r_dat <= dat;
         r_dp  <= dp_mask;
      end
   end

`ifdef SEG_PWM_EN
   logic [2:0] r_pwm;

   // Free-running brightness counter, wraps 7 -> 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= r_pwm + 3'd1;
      end
   end

   assign w_pwm_on = (r_pwm <= bright);
`else
   logic w_unused_bright;

   assign w_unused_bright = ^bright;
   assign w_pwm_on        = 1'b1;
`endif

   assign w_nib = r_dat[{r_idx, 2'b00} +: 4];

   // w_lz[i]: shadow nibbles NDIG-1 down to i are all zero
   always_comb begin
      w_lz         = '0;
      w_lz[NDIG-1] = (r_dat[4*(NDIG-1) +: 4] == 4'h0);
      for (int unsigned k = 1; k < NDIG; k++) begin
         w_lz[NDIG-1-k] = w_lz[NDIG-k] && (r_dat[4*(NDIG-1-k) +: 4] == 4'h0);
      end
   end

   // Digit 0 is never blanked so a zero value still shows a single 0
   assign w_blank = blank_lz && (r_idx != '0) && w_lz[r_idx];

   // Hex nibble to active-low gfedcba pattern
   always_comb begin
      w_seg_dec = 7'h7F;
      case (w_nib)
         4'h0: w_seg_dec = 7'b1000000;
         4'h1: w_seg_dec = 7'b1111001;
         4'h2: w_seg_dec = 7'b0100100;
         4'h3: w_seg_dec = 7'b0110000;
         4'h4: w_seg_dec = 7'b0011001;
         4'h5: w_seg_dec = 7'b0010010;
         4'h6: w_seg_dec = 7'b0000010;
         4'h7: w_seg_dec = 7'b1111000;
         4'h8: w_seg_dec = 7'b0000000;
         4'h9: w_seg_dec = 7'b0010000;
         4'hA: w_seg_dec = 7'b0001000;
         4'hB: w_seg_dec = 7'b0000011;
         4'hC: w_seg_dec = 7'b1000110;
         4'hD: w_seg_dec = 7'b0100001;
         4'hE: w_seg_dec = 7'b0000110;
         default: w_seg_dec = 7'b0001110;
      endcase
   end

   // Output drive: blanking clears everything, PWM gates only the anodes
   always_comb begin
      AN      = '1;
      seg     = 7'h7F;
      seg_P   = 1'b1;
      ce_scan = w_ce;
      if (!w_blank) begin
         seg   = w_seg_dec;
         seg_P = ~r_dp[r_idx];
         if (w_pwm_on) begin
            AN = ~(NDIG'(1) << r_idx);
         end
      end
   end

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench for multi_digit_display (NDIG=4, DIV=4).
// The reference model tracks cycles since reset and derives digit slot,
// strobe and PWM phase arithmetically from that count.
module tb_multi_digit_display;

   localparam int unsigned NDIG = 4;
   localparam int unsigned DIV  = 4;
`ifdef SEG_PWM_EN
   localparam bit PWM_EN = 1'b1;
`else
   localparam bit PWM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [4*NDIG-1:0] dat = '0;
   logic [NDIG-1:0]   dp_mask = '0;
   logic              load = 1'b0;
   logic              blank_lz = 1'b0;
   logic [2:0]        bright = 3'd7;
   logic [NDIG-1:0]   AN;
   logic [6:0]        seg;
   logic              seg_P;
   logic              ce_scan;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // model state
   int unsigned       m_t = 0;
   logic [4*NDIG-1:0] m_dat = '0;
   logic [NDIG-1:0]   m_dp = '0;

   logic [6:0] seg_tbl [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   multi_digit_display #(
      .NDIG(NDIG),
      .FCLK_KHZ(4),
      .FSCAN_KHZ(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .dat(dat),
      .dp_mask(dp_mask),
      .load(load),
      .blank_lz(blank_lz),
      .bright(bright),
      .AN(AN),
      .seg(seg),
      .seg_P(seg_P),
      .ce_scan(ce_scan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
      end
   endtask

   function automatic int unsigned model_idx();
      return (m_t == 0) ? 0 : ((m_t - 1) / DIV) % NDIG;
   endfunction

   function automatic bit model_ce();
      return (m_t > 0) && (m_t % DIV == 0);
   endfunction

   task automatic check_model();
      int unsigned       idx;
      logic [4*NDIG-1:0] upper;
      bit                blank;
      bit                pwm_on;
      logic [NDIG-1:0]   an_exp;
      logic [6:0]        seg_exp;
      logic              segp_exp;
      idx      = model_idx();
      upper    = m_dat >> (4 * idx);
      blank    = blank_lz && (idx != 0) && (upper == 0);
      pwm_on   = !PWM_EN || ((m_t % 8) <= bright);
      an_exp   = (blank || !pwm_on) ? '1 : ~(NDIG'(1) << idx);
      seg_exp  = blank ? 7'h7F : seg_tbl[upper[3:0]];
      segp_exp = blank ? 1'b1 : ~m_dp[idx];
      chk("AN", 32'(AN), 32'(an_exp));
      chk("seg", 32'(seg), 32'(seg_exp));
      chk("seg_P", 32'(seg_P), 32'(segp_exp));
      chk("ce_scan", 32'(ce_scan), 32'(model_ce()));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_t   = 0;
         m_dat = '0;
         m_dp  = '0;
      end else begin
         m_t++;
         if (load) begin
            m_dat = dat;
            m_dp  = dp_mask;
         end
      end
      #1;
      check_model();
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   initial begin
      // reset state
      dat = 16'hFFFF; dp_mask = 4'hF; load = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; load = 1'b0;
      chk("rst_AN", 32'(AN), 32'(4'b1110));
      chk("rst_seg", 32'(seg), 32'(7'b1000000));
      chk("rst_segP", 32'(seg_P), 32'd1);
      chk("rst_ce", 32'(ce_scan), 32'd0);

      // scan sequence
      run(20);

      // decode and decimal point
      dat = 16'h12AF; dp_mask = 4'b0100; load = 1'b1;
      tick();
      load = 1'b0;
      run(20);

      // leading-zero blanking on and off
      dat = 16'h0050; dp_mask = 4'b0000; load = 1'b1; blank_lz = 1'b1;
      tick();
      load = 1'b0;
      run(20);
      blank_lz = 1'b0;
      run(20);

      // brightness gating
      bright = 3'd2;
      run(32);
      bright = 3'd0;
      run(16);
      bright = 3'd7;

      // load on the strobe cycle
      for (int unsigned i = 0; i < 2 * DIV && !model_ce(); i++) tick();
      chk("ce_found", 32'(model_ce()), 32'd1);
      dat = 16'h9C3E; dp_mask = 4'b1010; load = 1'b1;
      tick();
      load = 1'b0;
      run(8);

      // reset mid-slot
      run(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_seg", 32'(seg), 32'(7'b1000000));
      chk("mid_rst_AN", 32'(AN), 32'(4'b1110));
      run(DIV + 2);

      // randomized traffic
      for (int unsigned i = 0; i < 300; i++) begin
         dat      = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
         dp_mask  = 4'($urandom);
         load     = ($urandom_range(0, 3) == 0);
         blank_lz = 1'($urandom);
         bright   = 3'($urandom);
         rst      = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 1'b0; load = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
